// File: rtl/ex_operand_stage_pkg.sv
// Shared encodings for the EX operand-preparation stage:
// opcodes, op types, immediate sizes and skid-buffer states.
package ex_operand_stage_pkg;

    localparam logic [3:0] OP_TYPE_3R   = 4'd1;
    localparam logic [3:0] OP_TYPE_2RI  = 4'd2;
    localparam logic [3:0] OP_TYPE_1RI  = 4'd3;
    localparam logic [3:0] OP_TYPE_BR   = 4'd4;

    localparam logic [7:0] OP_ADD_W     = 8'h01;
    localparam logic [7:0] OP_SUB_W     = 8'h02;
    localparam logic [7:0] OP_AND       = 8'h03;
    localparam logic [7:0] OP_ADDI_W    = 8'h10;
    localparam logic [7:0] OP_ANDI      = 8'h11;
    localparam logic [7:0] OP_LU12I_W   = 8'h12;
    localparam logic [7:0] OP_PCADDU12I = 8'h13;
    localparam logic [7:0] OP_SLLI_W    = 8'h20;
    localparam logic [7:0] OP_SRLI_W    = 8'h21;
    localparam logic [7:0] OP_SRAI_W    = 8'h22;
    localparam logic [7:0] OP_BL        = 8'h30;

    localparam logic [2:0] IMM_SZ_8     = 3'd0;
    localparam logic [2:0] IMM_SZ_12    = 3'd1;
    localparam logic [2:0] IMM_SZ_14    = 3'd2;
    localparam logic [2:0] IMM_SZ_16    = 3'd3;
    localparam logic [2:0] IMM_SZ_20    = 3'd4;
    localparam logic [2:0] IMM_SZ_26    = 3'd5;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic logic is_shift_imm(input logic [7:0] op);
        return (op == OP_SLLI_W) || (op == OP_SRLI_W) || (op == OP_SRAI_W);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_select.sv
// Priority forwarding for one source register: lowest index wins,
// r0 never forwards, and a hit on unfinished data flags pending.
module ex_operand_stage_fwd_select #(
    parameter int W       = 32,
    parameter int NUM_FWD = 3
) (
    input  logic [4:0]           addr_i,
    input  logic [W-1:0]         rf_data_i,
    input  logic [NUM_FWD-1:0]   fwd_valid_i,
    input  logic [NUM_FWD-1:0]   fwd_data_ok_i,
    input  logic [5*NUM_FWD-1:0] fwd_addr_i,
    input  logic [W*NUM_FWD-1:0] fwd_data_i,
    output logic [W-1:0]         data_o,
    output logic                 pending_o
);

    logic hit;

    always_comb begin
        data_o    = rf_data_i;
        pending_o = 1'b0;
        hit       = 1'b0;
        if (addr_i == 5'd0) begin
            data_o = '0;
        end else begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!hit && fwd_valid_i[i] && (fwd_addr_i[5*i +: 5] == addr_i)) begin
                    hit       = 1'b1;
                    data_o    = fwd_data_i[W*i +: W];
                    pending_o = !fwd_data_ok_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// Head of EX: forwards rj/rk, extends immediates, picks alu_in1/alu_in2
// and hands them to the ALU through a two-entry skid buffer.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int W       = 32,
    parameter int NUM_FWD = 3,
    parameter int DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           op,
    input  logic [3:0]           op_type,
    input  logic [4:0]           rj_addr,
    input  logic [4:0]           rk_addr,
    input  logic [W-1:0]         rj_data,
    input  logic [W-1:0]         rk_data,
    input  logic [W-1:0]         pc,
    input  logic [25:0]          imm_unext,
    input  logic [2:0]           imm_sz,
    input  logic [4:0]           shift_imm,
    input  logic                 flag_unsigned,
    input  logic                 in1_sel_pc,
    input  logic [NUM_FWD-1:0]   fwd_valid,
    input  logic [NUM_FWD-1:0]   fwd_data_ok,
    input  logic [5*NUM_FWD-1:0] fwd_addr,
    input  logic [W*NUM_FWD-1:0] fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         alu_in1,
    output logic [W-1:0]         alu_in2,
    output logic [7:0]           out_op
);

    logic [W-1:0] rj_val;
    logic [W-1:0] rk_val;
    logic         rj_pend;
    logic         rk_pend;

    ex_operand_stage_fwd_select #(
        .W       (W),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_rj (
        .addr_i        (rj_addr),
        .rf_data_i     (rj_data),
        .fwd_valid_i   (fwd_valid),
        .fwd_data_ok_i (fwd_data_ok),
        .fwd_addr_i    (fwd_addr),
        .fwd_data_i    (fwd_data),
        .data_o        (rj_val),
        .pending_o     (rj_pend)
    );

    ex_operand_stage_fwd_select #(
        .W       (W),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_rk (
        .addr_i        (rk_addr),
        .rf_data_i     (rk_data),
        .fwd_valid_i   (fwd_valid),
        .fwd_data_ok_i (fwd_data_ok),
        .fwd_addr_i    (fwd_addr),
        .fwd_data_i    (fwd_data),
        .data_o        (rk_val),
        .pending_o     (rk_pend)
    );

    logic is_3r;
    logic shift_op;
    logic rj_used;
    logic rk_used;
    logic pending;

    assign is_3r    = (op_type == OP_TYPE_3R);
    assign shift_op = is_shift_imm(op);
    assign rj_used  = !in1_sel_pc;
    assign rk_used  = is_3r && !shift_op;
    // Only an operand that actually feeds the ALU may hold the op back.
    assign pending  = (rj_used && rj_pend) || (rk_used && rk_pend);

    logic [W-1:0] imm_ext;

    always_comb begin
        imm_ext = '0;
        case (imm_sz)
            IMM_SZ_8:  imm_ext = W'($signed(imm_unext[7:0]));
            IMM_SZ_12: imm_ext = flag_unsigned ? W'(imm_unext[11:0])
                                               : W'($signed(imm_unext[11:0]));
            IMM_SZ_14: imm_ext = W'($signed(imm_unext[13:0]));
            IMM_SZ_16: imm_ext = W'($signed(imm_unext[15:0]));
            IMM_SZ_20: imm_ext = W'($signed({imm_unext[19:0], 12'b0}));
            IMM_SZ_26: imm_ext = W'($signed(imm_unext[25:0]));
            default:   imm_ext = '0;
        endcase
    end

    logic [W-1:0] in1_new;
    logic [W-1:0] in2_new;

    always_comb begin
        in1_new = in1_sel_pc ? pc : rj_val;
        in2_new = imm_ext;
        if (is_3r) begin
            in2_new = shift_op ? W'(shift_imm) : rk_val;
        end
    end

    skid_state_e state_q;
    skid_state_e state_d;
    logic        accept;
    logic        pop;
    logic        ld_head;
    logic        ld_tail;
    logic        advance;

    assign in_ready  = (state_q != SKID_FULL);
    assign out_valid = (state_q != SKID_EMPTY);
    assign accept    = in_valid && in_ready && !pending && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_head = 1'b0;
        ld_tail = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d = SKID_ONE;
                    ld_head = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && pop) begin
                    ld_head = 1'b1;
                end else if (accept) begin
                    state_d = SKID_FULL;
                    ld_tail = 1'b1;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (pop) begin
                    state_d = SKID_ONE;
                    advance = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        if (flush) begin
            state_d = SKID_EMPTY;
            ld_head = 1'b0;
            ld_tail = 1'b0;
            advance = 1'b0;
        end
    end

    // Entry 0 is always the oldest op; entry 1 only fills while stalled.
    logic [W-1:0] in1_q [DEPTH];
    logic [W-1:0] in2_q [DEPTH];
    logic [7:0]   op_q  [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                in1_q[i] <= '0;
                in2_q[i] <= '0;
                op_q[i]  <= '0;
            end
        end else begin
            if (ld_head) begin
                in1_q[0] <= in1_new;
                in2_q[0] <= in2_new;
                op_q[0]  <= op;
            end
            if (advance) begin
                in1_q[0] <= in1_q[1];
                in2_q[0] <= in2_q[1];
                op_q[0]  <= op_q[1];
            end
            if (ld_tail) begin
                in1_q[1] <= in1_new;
                in2_q[1] <= in2_new;
                op_q[1]  <= op;
            end
        end
    end

    assign alu_in1 = in1_q[0];
    assign alu_in2 = in2_q[0];
    assign out_op  = op_q[0];

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Registered operand-preparation stage at the head of EX. Accepts decoded ops from ID over a valid/ready handshake.
- Resolves rj/rk against N forwarding sources, extends immediates across all LA32 immediate sizes, selects alu_in1/alu_in2, and presents them to the ALU through a 2-entry skid buffer.
- Successor to the single combinational in2 mux: both operands, width- and forward-count-parametrised, with stalling and flush.

Parameters:
- W, 32, datapath width; must be ≥ 32.
- NUM_FWD, 3, number of forwarding sources; index 0 is the youngest (highest priority).
- DEPTH, 2, output buffer entries; fixed at 2 (skid).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; drops all buffered and incoming ops
- in_valid  in  1  ID op valid
- in_ready  out  1  stage can accept this cycle
- op  in  8  opcode (`OP_*)
- op_type  in  4  `OP_TYPE_*
- rj_addr, rk_addr  in  5 each  source register numbers
- rj_data, rk_data  in  W each  regfile read data
- pc  in  W  op PC
- imm_unext  in  26  raw immediate
- imm_sz  in  3  `IMM_SZ_*
- shift_imm  in  5  shift amount for SLLI/SRLI/SRAI
- flag_unsigned  in  1  zero-extend the 12-bit immediate
- in1_sel_pc  in  1  alu_in1 = pc (PCADDU12I, B/BL link)
- fwd_valid  in  NUM_FWD  source holds a write to fwd_addr
- fwd_data_ok  in  NUM_FWD  source data is final (0 = load/mul pending)
- fwd_addr  in  5*NUM_FWD  destination registers, packed
- fwd_data  in  W*NUM_FWD  results, packed
- out_valid  out  1  operands valid
- out_ready  in  1  ALU accepts
- alu_in1, alu_in2  out  W each  operands
- out_op  out  8  registered op

Behaviour:
- Reset (async): both buffer entries invalid; out_valid=0; in_ready=1; alu_in1, alu_in2, out_op = 0.
- Forwarding per source register:
  - addr 0 → value 0, never forwarded.
  - Otherwise the lowest-index i with fwd_valid[i] and fwd_addr[i]==addr wins. If fwd_data_ok[i]=1, use fwd_data[i]; else the operand is pending.
  - No hit → regfile data.
- Operand used: rj for in1 unless in1_sel_pc. rk for in2 only when op_type==`OP_TYPE_3R and op is not SLLI/SRLI/SRAI.
  - A pending operand that is not used does not stall.
- Immediate extension to W bits:
  - 8, 14, 16, 26: sign-extend.
  - 12: zero-extend if flag_unsigned, else sign-extend.
  - `IMM_SZ_20: {imm[19:0], 12'b0} sign-extended to W.
  - Unknown encoding → 0.
- in2 select:
  - 3R non-shift-imm → rk.
  - 3R shift-imm → zero-extended shift_imm.
  - Else → imm_ext.
- Acceptance: accept = in_valid & in_ready & !pending & !flush. Operands are captured in the same cycle and appear on outputs the next cycle (latency 1).
- Skid buffer states EMPTY / ONE / FULL:
  - in_ready = (state != FULL), registered, so it never depends combinationally on out_ready.
  - Outputs always show the oldest entry; pop on out_valid & out_ready.
  - Simultaneous push and pop in ONE: stays ONE, contents advance.
  - Push without pop in ONE → FULL. Pop in FULL → ONE; no push occurs that cycle, since in_ready was 0.
- Pending operand while in_valid: no accept. in_ready stays as the state dictates; ID must hold its inputs. Acceptance resumes the cycle fwd_data_ok rises.
- flush: next state EMPTY, out_valid=0 next cycle; any op presented that cycle is dropped. flush overrides a simultaneous push/pop.
- alu_in1/alu_in2 hold their value while out_valid & !out_ready (stable under stall).

Decomposition:
- defs.v gains `IMM_SZ_16, `IMM_SZ_20, `IMM_SZ_26 alongside the existing 8/12/14.
- Sub-module fwd_select (parametrised NUM_FWD, W): priority forwarding plus pending flag. Instanced twice, for rj and rk.
- Immediate extension and the in2 mux stay inline.

Test Plan:
- ADDI.W, imm_sz=12, imm=0xFFF, flag_unsigned=0, rj=5 (rf 0x10), no fwd → next cycle alu_in1=0x10, alu_in2=0xFFFFFFFF.
- ANDI, flag_unsigned=1, imm=0xFFF → alu_in2=0x00000FFF. LU12I.W, imm_sz=20, imm=0x80000 → alu_in2=0x80000000.
- ADD.W rk=7; fwd0 and fwd2 both addr 7 with data 0x11/0x22 → alu_in2=0x11. Same with rk=0 → alu_in2=0.
- rj=3 hit on fwd1 with fwd_data_ok=0 for 3 cycles → no out_valid. ok rises → captured, out_valid the following cycle. SLLI.W with rk pending → no stall, alu_in2=shift_imm.
- out_ready=0, push 3 ops back-to-back → in_ready drops after 2. Release → ops A, B, C emerge in order, alu_in* stable while stalled.
- flush with FULL plus in_valid → out_valid=0 next cycle, no op delivered. Reset asserted mid-stream asynchronously → outputs 0 immediately.
